// File: rtl/ej32_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ej32_mem_arb                                                     |
// | Brief    : Round-robin multi-channel arbiter and 1/2/4-byte to byte-wide    |
// |            big-endian width adapter for the mb8_io SRAM port.               |
// | Option   : EJ32_ARB_SEXT_EN - sign-extend byte/half reads into rdata_o.     |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ej32_mem_arb #(
    parameter int NCH = 2,
    parameter int AW  = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      req_i,
    input  logic [NCH-1:0]      we_i,
    input  logic [2*NCH-1:0]    sz_i,
    input  logic [NCH*AW-1:0]   addr_i,
    input  logic [32*NCH-1:0]   wdata_i,
    output logic [NCH-1:0]      ack_o,
    output logic [31:0]         rdata_o,
    output logic                busy_o,
    output logic [AW-1:0]       m_addr_o,
    output logic                m_we_o,
    output logic [7:0]          m_wdata_o,
    input  logic [7:0]          m_rdata_i
);

    localparam int c_cw = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef EJ32_ARB_SEXT_EN
    localparam logic c_sext = 1'b1;
`else
    localparam logic c_sext = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_cw-1:0]   r_rr;
    logic [c_cw-1:0]   r_g;
    logic              r_we;
    logic [1:0]        r_nm1;      // byte count minus one: 0, 1 or 3
    logic [1:0]        r_k;
    logic [AW-1:0]     r_base;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rd;

    logic              w_any;
    logic [c_cw-1:0]   w_gnt;
    logic [c_cw-1:0]   w_cand;
    int                w_idx;
    logic [1:0]        w_gsz;
    logic [1:0]        w_gnm1;
    logic [c_cw-1:0]   w_rr_nxt;
    logic              w_xfer;
    logic              w_last;
    logic [1:0]        w_bidx;

    // Round-robin search: first requester at or after r_rr wins.
    always_comb begin
        w_any  = 1'b0;
        w_gnt  = r_rr;
        w_cand = r_rr;
        w_idx  = 0;
        for (int i = 0; i < NCH; i++) begin
            w_idx = int'(r_rr) + i;
            if (w_idx >= NCH) begin
                w_idx = w_idx - NCH;
            end
            w_cand = c_cw'(w_idx);
            if (!w_any && req_i[w_cand]) begin
                w_any = 1'b1;
                w_gnt = w_cand;
            end
        end
    end

    assign w_gsz    = sz_i[int'(w_gnt)*2 +: 2];
    assign w_gnm1   = (w_gsz == 2'd0) ? 2'd0 : (w_gsz == 2'd1) ? 2'd1 : 2'd3;
    assign w_rr_nxt = (int'(w_gnt) == NCH - 1) ? '0 : w_gnt + c_cw'(1);
    assign w_xfer   = (r_state == ST_XFER);
    assign w_last   = (r_k == r_nm1);
    assign w_bidx   = r_nm1 - r_k;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_nxt = ST_XFER;
            ST_XFER: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_rr    <= '0;
            r_g     <= '0;
            r_we    <= 1'b0;
            r_nm1   <= 2'd0;
            r_k     <= 2'd0;
            r_base  <= '0;
            r_wdata <= 32'd0;
            r_rd    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_g     <= w_gnt;
                        r_we    <= we_i[w_gnt];
                        r_nm1   <= w_gnm1;
                        r_k     <= 2'd0;
                        r_base  <= addr_i[int'(w_gnt)*AW +: AW];
                        r_wdata <= wdata_i[int'(w_gnt)*32 +: 32];
                        r_rd    <= 32'd0;
                        r_rr    <= w_rr_nxt;
                    end
                end
                ST_XFER: begin
                    // Memory returns the byte within the cycle (falling-edge sampled).
                    r_rd <= {r_rd[23:0], m_rdata_i};
                    if (!w_last) begin
                        r_k <= r_k + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o    = (r_state != ST_IDLE);
    assign m_we_o    = w_xfer & r_we;
    assign m_addr_o  = w_xfer ? (r_base + AW'(r_k)) : '0;
    assign m_wdata_o = (w_xfer && r_we) ? r_wdata[{w_bidx, 3'b000} +: 8] : 8'd0;

    always_comb begin
        ack_o = '0;
        if (r_state == ST_DONE) begin
            ack_o[r_g] = 1'b1;
        end
    end

    always_comb begin
        rdata_o = 32'd0;
        if (r_state == ST_DONE && !r_we) begin
            case (r_nm1)
                2'd0:    rdata_o = {{24{c_sext & r_rd[7]}},  r_rd[7:0]};
                2'd1:    rdata_o = {{16{c_sext & r_rd[15]}}, r_rd[15:0]};
                default: rdata_o = r_rd;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ej32_mem_arb.sv
`default_nettype none
// Scoreboard bench for ej32_mem_arb: byte-array reference model predicts the
// memory-port byte stream and each ack (channel, data, cycle).
module tb_ej32_mem_arb;
    localparam int NCH = 2;
    localparam int AW  = 17;
    localparam int MSZ = 1 << AW;
`ifdef EJ32_ARB_SEXT_EN
    localparam bit SEXT = 1'b1;
`else
    localparam bit SEXT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH-1:0]    req = '0;
    logic [NCH-1:0]    we = '0;
    logic [2*NCH-1:0]  sz = '0;
    logic [NCH*AW-1:0] addr = '0;
    logic [32*NCH-1:0] wdata = '0;
    logic [NCH-1:0]    ack_o;
    logic [31:0]       rdata_o;
    logic              busy_o;
    logic [AW-1:0]     m_addr_o;
    logic              m_we_o;
    logic [7:0]        m_wdata_o;
    logic [7:0]        m_rdata_i;

    ej32_mem_arb #(.NCH(NCH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .sz_i(sz), .addr_i(addr),
        .wdata_i(wdata), .ack_o(ack_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_wdata_o(m_wdata_o),
        .m_rdata_i(m_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: write on the falling edge, combinational read.
    logic [7:0] mem [0:MSZ-1];
    logic [7:0] ref_mem [0:MSZ-1];
    assign m_rdata_i = mem[m_addr_o];
    initial begin
        for (int i = 0; i < MSZ; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[17'h1000] = 8'h12; mem[17'h1001] = 8'h34;
        mem[17'h1002] = 8'h56; mem[17'h1003] = 8'h78;
        for (int i = 0; i < 4; i++) mem[17'h2000 + i] = 8'hFF;
        mem[17'h1800] = 8'h80;
        forever begin
            @(negedge clk);
            if (m_we_o) mem[m_addr_o] = m_wdata_o;
        end
    end

    typedef struct { int ch; logic [31:0] rdata; int cyc; } ack_t;
    typedef struct { logic [AW-1:0] addr; logic we; logic [7:0] wd; } bus_t;
    ack_t ackq[$];
    bus_t busq[$];
    int   model_rr = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s: got timeout expected event (cycle %0d)", nm, cyc);
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    // Reference model: plain byte arithmetic over the shadow memory.
    task automatic model_txn(input int ch, input logic w, input logic [1:0] s,
                             input logic [AW-1:0] a, input logic [31:0] d, input int ack_cyc);
        int n;
        logic [31:0] v;
        logic [31:0] tmp;
        logic [AW-1:0] ad;
        bus_t b;
        ack_t e;
        n = nbytes(s);
        v = 32'd0;
        for (int k = 0; k < n; k++) begin
            ad = a + AW'(k);
            b.addr = ad;
            b.we = w;
            if (w) begin
                tmp = d >> (8 * (n - 1 - k));
                b.wd = tmp[7:0];
                ref_mem[ad] = b.wd;
            end else begin
                b.wd = 8'd0;
                v = (v << 8) | {24'd0, ref_mem[ad]};
            end
            busq.push_back(b);
        end
        if (SEXT && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (SEXT && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        e.ch = ch;
        e.rdata = w ? 32'd0 : v;
        e.cyc = ack_cyc;
        ackq.push_back(e);
        model_rr = (ch + 1) % NCH;
    endtask

    task automatic set_fields(input int ch, input logic w, input logic [1:0] s,
                              input logic [AW-1:0] a, input logic [31:0] d);
        we[ch] = w;
        sz[2*ch +: 2] = s;
        addr[ch*AW +: AW] = a;
        wdata[32*ch +: 32] = d;
    endtask

    task automatic do_txn(input int ch, input logic w, input logic [1:0] s,
                          input logic [AW-1:0] a, input logic [31:0] d);
        int t;
        @(negedge clk);
        set_fields(ch, w, s, a, d);
        req[ch] = 1'b1;
        model_txn(ch, w, s, a, d, cyc + nbytes(s) + 1);
        t = 0;
        forever begin
            @(negedge clk);
            if (ack_o[ch]) break;
            // Fields after grant must be ignored.
            set_fields(ch, 1'($urandom), 2'($urandom), AW'($urandom), $urandom);
            t++;
            if (t > 40) begin fail_now("txn_ack_timeout"); break; end
        end
        req[ch] = 1'b0;
    endtask

    task automatic do_pair(input logic w0, input logic [1:0] s0, input logic [AW-1:0] a0, input logic [31:0] d0,
                           input logic w1, input logic [1:0] s1, input logic [AW-1:0] a1, input logic [31:0] d1);
        int t, first, nf, c0;
        @(negedge clk);
        set_fields(0, w0, s0, a0, d0);
        set_fields(1, w1, s1, a1, d1);
        req = 2'b11;
        c0 = cyc;
        first = model_rr;
        if (first == 0) begin
            nf = nbytes(s0);
            model_txn(0, w0, s0, a0, d0, c0 + nf + 1);
            model_txn(1, w1, s1, a1, d1, c0 + nf + 2 + nbytes(s1) + 1);
        end else begin
            nf = nbytes(s1);
            model_txn(1, w1, s1, a1, d1, c0 + nf + 1);
            model_txn(0, w0, s0, a0, d0, c0 + nf + 2 + nbytes(s0) + 1);
        end
        t = 0;
        while (req != 2'b00) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) if (ack_o[i]) req[i] = 1'b0;
            t++;
            if (t > 60) begin fail_now("pair_ack_timeout"); req = 2'b00; end
        end
    endtask

    // Monitor: compare every ack and every transfer cycle against the queues.
    always @(negedge clk) begin
        ack_t a;
        bus_t b;
        if (ack_o != '0) begin
            if (ackq.size() == 0) fail_now("unexpected_ack");
            else begin
                a = ackq.pop_front();
                chk("ack_onehot", 32'(ack_o), 32'(1) << a.ch);
                chk("rdata", rdata_o, a.rdata);
                chk("ack_cycle", cyc, a.cyc);
                chk("done_m_we", 32'(m_we_o), 32'd0);
            end
        end else if (busy_o) begin
            if (busq.size() == 0) fail_now("unexpected_xfer");
            else begin
                b = busq.pop_front();
                chk("m_addr", 32'(m_addr_o), 32'(b.addr));
                chk("m_we", 32'(m_we_o), 32'(b.we));
                if (b.we) chk("m_wdata", 32'(m_wdata_o), 32'(b.wd));
            end
        end else begin
            chk("idle_m_we", 32'(m_we_o), 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, t, c0, chs, pr;
        for (int i = 0; i < MSZ; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        ref_mem[17'h1000] = 8'h12; ref_mem[17'h1001] = 8'h34;
        ref_mem[17'h1002] = 8'h56; ref_mem[17'h1003] = 8'h78;
        for (int i = 0; i < 4; i++) ref_mem[17'h2000 + i] = 8'hFF;
        ref_mem[17'h1800] = 8'h80;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_m_addr", 32'(m_addr_o), 32'd0);
        chk("rst_m_wdata", 32'(m_wdata_o), 32'd0);
        rst = 1'b1;

        do_txn(0, 1'b0, 2'd2, 17'h1000, 32'd0);
        do_txn(1, 1'b1, 2'd2, 17'h1400, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) do_txn(0, 1'b0, 2'd0, AW'(17'h1400 + i), 32'd0);
        do_txn(1, 1'b0, 2'd0, 17'h1001, 32'd0);

        // Continuous contention: both channels hold byte reads.
        @(negedge clk);
        set_fields(0, 1'b0, 2'd0, 17'h1000, 32'd0);
        set_fields(1, 1'b0, 2'd0, 17'h1003, 32'd0);
        req = 2'b11;
        c0 = cyc;
        for (int j = 0; j < 8; j++) begin
            chs = model_rr;
            model_txn(chs, 1'b0, 2'd0, (chs == 0) ? 17'h1000 : 17'h1003, 32'd0, c0 + 2 + 3 * j);
        end
        k = 0; t = 0;
        while (k < 8) begin
            @(negedge clk);
            if (ack_o != '0) k++;
            t++;
            if (t > 60) begin fail_now("contention_timeout"); k = 8; end
        end
        req = 2'b00;

        do_txn(0, 1'b1, 2'd1, 17'h1FFFF, 32'h0000_A5C3);
        do_txn(1, 1'b0, 2'd1, 17'h1FFFF, 32'd0);
        do_txn(1, 1'b0, 2'd0, 17'h00000, 32'd0);
        do_txn(0, 1'b0, 2'd0, 17'h1800, 32'd0);

        // Reset during the 2nd transfer cycle of a word write.
        @(negedge clk);
        set_fields(0, 1'b1, 2'd2, 17'h2000, 32'h1122_3344);
        req[0] = 1'b1;
        busq.push_back('{addr: 17'h2000, we: 1'b1, wd: 8'h11});
        ref_mem[17'h2000] = 8'h11;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        rst = 1'b0;
        req[0] = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_ack", 32'(ack_o), 32'd0);
        chk("abort_rdata", rdata_o, 32'd0);
        chk("abort_m_we", 32'(m_we_o), 32'd0);
        chk("abort_m_addr", 32'(m_addr_o), 32'd0);
        chk("abort_m_wdata", 32'(m_wdata_o), 32'd0);
        model_rr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_pair(1'b0, 2'd2, 17'h2000, 32'd0, 1'b0, 2'd0, 17'h1003, 32'd0);

        // Randomized traffic, including wrap-around addresses and contention.
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] ra0, ra1;
            ra0 = ($urandom_range(0, 3) == 0) ? AW'(17'h1FFFE + $urandom_range(0, 3)) : AW'(17'h3000 + $urandom_range(0, 31));
            ra1 = AW'(17'h3000 + $urandom_range(0, 31));
            pr = $urandom_range(0, 3);
            if (pr == 0)
                do_pair(1'($urandom), 2'($urandom), ra0, $urandom, 1'($urandom), 2'($urandom), ra1, $urandom);
            else
                do_txn($urandom_range(0, 1), 1'($urandom), 2'($urandom), ra0, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("ackq_drained", 32'(ackq.size()), 32'd0);
        chk("busq_drained", 32'(busq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ej32_mem_arb.md
# ej32_mem_arb

Multi-channel memory arbiter and width adapter between eJ32-side requesters (core, host loader, TIB/OBUF console DMA) and the single byte-wide `mb8_io` SRAM port (`spram8_128k`). It grants one channel at a time with round-robin fairness, then splits each 1-, 2- or 4-byte access into sequential big-endian byte cycles. This replaces the direct single-master, byte-only combinational hookup in the top level.

## Interface
- `NCH`, 2: number of requester channels (1..8).
- `AW`, 17: byte address width; 17 covers the 128 KB SRAM.
- `clk` in 1: system clock. The memory is clocked on `~clk`.
- `rst` in 1: asynchronous, active-low reset.
- `req_i` in NCH: per-channel request. Held high until `ack_o` of that channel.
- `we_i` in NCH: per-channel write enable; 1 = write, 0 = read.
- `sz_i` in NCH×2: per-channel size. 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- `addr_i` in NCH×AW: per-channel start byte address.
- `wdata_i` in NCH×32: per-channel write data, right-justified.
- `ack_o` out NCH: one-cycle completion pulse for the granted channel.
- `rdata_o` out 32: shared read data. Valid only in the `ack_o` cycle.
- `busy_o` out 1: high when state ≠ IDLE.
- `m_addr_o` out AW: memory byte address.
- `m_we_o` out 1: memory write strobe. 1 selects `put_u8`; 0 selects `get_u8`.
- `m_wdata_o` out 8: memory write byte.
- `m_rdata_i` in 8: memory read byte. Valid at the end of the same cycle, because the memory samples on the falling edge.

## Operation
- FSM states and transitions:
  - IDLE → XFER when any `req_i` is high.
  - XFER → DONE after the last byte.
  - DONE → IDLE unconditionally.
- **Arbitration (in IDLE):**
  - Round-robin search starts at pointer `rr`.
  - The first requesting channel is granted.
  - At grant: latch channel index `g`, `we`, byte count N (1/2/4), base address and write data. Byte count is cleared.
  - `rr` ← `g+1` mod NCH.
- **XFER, byte k (k = 0..N−1):**
  - `m_addr_o` = (base + k) mod 2^AW, so the address wraps from 0x1FFFF to 0x00000.
  - Big-endian ordering: byte k = bits [8(N−1−k)+7 : 8(N−1−k)] of the right-justified write data.
  - Writes: `m_we_o` = 1 and `m_wdata_o` = byte k.
  - Reads: `m_we_o` = 0; shift register `rd` ← {rd[23:0], `m_rdata_i`} at each XFER edge.
- **DONE:**
  - `ack_o[g]` = 1; all other ack bits are 0.
  - `rdata_o` = `rd` masked to N bytes (zero-extended, see Configuration).
  - For writes, `rdata_o` = 0.
- **Requests:**
  - `req_i` is sampled only in IDLE.
  - A requester must drop `req_i` by the edge ending its ack cycle. A req still high in the next IDLE is a new transaction.
  - Request fields are ignored after grant. Changes during XFER have no effect.
- **Outside XFER:** `m_we_o` = 0, `m_addr_o` = 0, `m_wdata_o` = 0.
- **Reset (async, any time including mid-transfer):**
  - State → IDLE; `rr` = 0; `ack_o`, `rdata_o`, `busy_o`, `m_*` outputs all 0.
  - A partially written word stays partially written in memory. No ack is issued for the aborted transaction.

## Timing
- Cycle 0: IDLE, request sampled.
- Cycles 1..N: XFER, one byte per cycle.
- Cycle N+1: DONE, `ack_o` and `rdata_o` valid.
- Cycle N+2: IDLE.
- Latency from req to ack: byte = 2, half = 3, word = 5 cycles.
- Minimum transaction period is N+2 cycles. Peak bandwidth: 4 bytes / 6 cycles.
- Simultaneous requests: exactly one grant. A contending channel waits at most NCH−1 transactions.
- `busy_o` is high during cycles 1..N+1.

## Configuration
- `EJ32_ARB_SEXT_EN`:
  - Defined: byte and half reads are sign-extended into `rdata_o`, per JVM `baload`/`saload` semantics.
  - Undefined: byte and half reads are zero-extended.
  - Word reads and all writes are unaffected either way.

## Test plan
- Preload 0x1000..0x1003 = 12 34 56 78; ch0 word read at 0x1000 → `ack_o[0]` in cycle 5, `rdata_o` = 0x12345678, `m_we_o` never high.
- ch1 word write 0xDEADBEEF at 0x1400, then ch0 byte reads at 0x1400..0x1403 → 0xDE, 0xAD, 0xBE, 0xEF (zero-extended); `m_wdata_o` sequence DE, AD, BE, EF.
- ch0 and ch1 both hold byte-read requests continuously with `rr` = 0 → grants alternate 0, 1, 0, 1; a new ack every 3 cycles.
- Half write 0xA5C3 at 0x1FFFF → bytes land at 0x1FFFF = A5 and 0x00000 = C3; half read at 0x1FFFF returns 0xA5C3 without the macro, 0xFFFFA5C3 with `EJ32_ARB_SEXT_EN`.
- Word write 0x11223344 at 0x2000 over memory pre-filled with 0xFF; assert `rst` low during the 2nd XFER cycle → all outputs 0 immediately, no ack issued; memory reads 11 FF FF FF; next request is served normally starting from ch0.
- Byte read of 0x80 → `rdata_o` = 0x00000080 without the macro, 0xFFFFFF80 with it.
